// File: rtl/card_deck_sequencer_if.sv
// ----------------------------------------------------------------------------
// card_deck_sequencer_if
//   Digit stream from the card deck sequencer to the conversion datapath.
//
//   Handshake: the master raises digit_valid and holds digit, digit_col and
//   digit_card stable until a clock edge at which digit_valid && digit_ready
//   are both high; that edge is the transfer. digit_valid never depends on
//   digit_ready, and it is only withdrawn without a transfer by abort/rst.
//
//   Signals:
//     digit_valid  master -> slave  digit presented
//     digit_ready  slave  -> master consumer accepts digit
//     digit        master -> slave  column nibble (0..9, or A..E if unchecked)
//     digit_col    master -> slave  column index 0..4, 0 = card bits [19:16]
//     digit_card   master -> slave  card address the digit came from
// ----------------------------------------------------------------------------
interface card_deck_sequencer_if;
    logic       digit_valid;
    logic       digit_ready;
    logic [3:0] digit;
    logic [2:0] digit_col;
    logic [3:0] digit_card;

    modport master (
        output digit_valid,
        output digit,
        output digit_col,
        output digit_card,
        input  digit_ready
    );

    modport slave (
        input  digit_valid,
        input  digit,
        input  digit_col,
        input  digit_card,
        output digit_ready
    );
endinterface

// File: rtl/card_deck_sequencer.sv
// ----------------------------------------------------------------------------
// card_deck_sequencer
//   Walks one deck of the punch-card ROM (equation deck or power-of-10 mask
//   deck), card addresses 0..N_CARDS-1, stopping at the first blank card or
//   after the last card, and streams every punched column out as a digit.
//
//   Optional build macro: CARD_BCD_CHECK_EN
//     defined   : a nibble A..E reached in EMIT is treated as a corrupt punch;
//                 it is not presented, sel_err pulses, then the deck ends.
//     undefined : A..E nibbles are emitted like any other digit.
//
//   Ports:
//     clk, rst         clock, synchronous active-high reset
//     start            begin a deck read (only honoured in IDLE)
//     abort            cancel the current deck read (wins over start)
//     sel_mask         deck select: 1 = mask deck, 0 = equation deck
//     sel_card         deck index, ROM card_slt encoding
//     card_slt, mask   latched deck select, to ROM
//     card_addr        card address, to ROM
//     card_in          ROM card_out (combinational from the three above)
//     dig              digit stream (master side)
//     busy             state != IDLE
//     done             one-cycle pulse at deck end
//     sel_err          one-cycle pulse on illegal select / corrupt punch
//     card_count       non-blank cards read in the last/current deck
//     state_dbg        current FSM state encoding
// ----------------------------------------------------------------------------
module card_deck_sequencer #(
    parameter int          N_CARDS    = 15,
    parameter logic [19:0] BLANK_CARD = 20'hFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        sel_mask,
    input  logic [1:0]  sel_card,
    output logic [1:0]  card_slt,
    output logic        mask,
    output logic [3:0]  card_addr,
    input  logic [19:0] card_in,
    card_deck_sequencer_if.master dig,
    output logic        busy,
    output logic        done,
    output logic        sel_err,
    output logic [3:0]  card_count,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SCAN  = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] LAST_ADDR = 4'(N_CARDS - 1);

    state_t      state, state_n;
    logic [19:0] card_reg;
    logic [2:0]  col;
    logic        sel_err_q;

    logic [3:0]  nibble;
    logic        nib_blank;
    logic        nib_bad;
    logic        emit_valid;
    logic        col_adv;
    logic        last_col;
    logic        last_card;
    logic        start_ok;
    logic        start_bad;

    // Equation deck with card_slt 00 selects nothing in the ROM (floating bus).
    assign start_ok  = (state == S_IDLE) && start && !abort && !(!sel_mask && sel_card == 2'b00);
    assign start_bad = (state == S_IDLE) && start && !abort &&  (!sel_mask && sel_card == 2'b00);

    always_comb begin
        nibble = 4'hF;
        case (col)
            3'd0:    nibble = card_reg[19:16];
            3'd1:    nibble = card_reg[15:12];
            3'd2:    nibble = card_reg[11:8];
            3'd3:    nibble = card_reg[7:4];
            3'd4:    nibble = card_reg[3:0];
            default: nibble = 4'hF;
        endcase
    end

    assign nib_blank = (nibble == 4'hF);

`ifdef CARD_BCD_CHECK_EN
    assign nib_bad = (state == S_EMIT) && (nibble >= 4'hA) && (nibble <= 4'hE);
`else
    assign nib_bad = 1'b0;
`endif

    // Valid is a function of state/col/card_reg only, never of digit_ready.
    assign emit_valid = (state == S_EMIT) && !nib_blank && !nib_bad;
    assign col_adv    = (state == S_EMIT) && !nib_bad && (nib_blank || dig.digit_ready);
    assign last_col   = (col == 3'd4);
    assign last_card  = (card_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start_ok) state_n = S_FETCH;
            S_FETCH: state_n = S_SCAN;
            S_SCAN:  state_n = (card_reg == BLANK_CARD) ? S_DONE : S_EMIT;
            S_EMIT: begin
                if (nib_bad)
                    state_n = S_DONE;
                else if (col_adv && last_col)
                    state_n = last_card ? S_DONE : S_FETCH;
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort && state != S_IDLE)
            state_n = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            card_slt   <= 2'b00;
            mask       <= 1'b0;
            card_addr  <= 4'd0;
            card_count <= 4'd0;
            card_reg   <= 20'd0;
            col        <= 3'd0;
            sel_err_q  <= 1'b0;
        end else begin
            sel_err_q <= start_bad;
            if (!abort) begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            mask       <= sel_mask;
                            card_slt   <= sel_card;
                            card_addr  <= 4'd0;
                            card_count <= 4'd0;
                        end
                    end
                    S_FETCH: card_reg <= card_in;
                    S_SCAN: begin
                        col <= 3'd0;
                        if (card_reg != BLANK_CARD)
                            card_count <= card_count + 4'd1;
                    end
                    S_EMIT: begin
                        if (col_adv) begin
                            if (last_col) begin
                                col <= 3'd0;
                                // Stay on the last card instead of wrapping to 0.
                                if (!last_card)
                                    card_addr <= card_addr + 4'd1;
                            end else begin
                                col <= col + 3'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dig.digit_valid = emit_valid;
    assign dig.digit       = emit_valid ? nibble    : 4'd0;
    assign dig.digit_col   = emit_valid ? col       : 3'd0;
    assign dig.digit_card  = emit_valid ? card_addr : 4'd0;

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign sel_err   = sel_err_q | nib_bad;
    assign state_dbg = state;

endmodule

// File: tb/tb_card_deck_sequencer.sv
module tb_card_deck_sequencer;

    localparam int W = 11;  // {card[3:0], col[2:0], digit[3:0]}

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic        sel_mask;
    logic [1:0]  sel_card;
    logic [1:0]  card_slt;
    logic        mask;
    logic [3:0]  card_addr;
    logic [19:0] card_in;
    logic        busy;
    logic        done;
    logic        sel_err;
    logic [3:0]  card_count;
    logic [2:0]  state_dbg;

    card_deck_sequencer_if dig_if ();

    card_deck_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .sel_mask   (sel_mask),
        .sel_card   (sel_card),
        .card_slt   (card_slt),
        .mask       (mask),
        .card_addr  (card_addr),
        .card_in    (card_in),
        .dig        (dig_if.master),
        .busy       (busy),
        .done       (done),
        .sel_err    (sel_err),
        .card_count (card_count),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- ROM model ----------------
    function automatic logic [19:0] rom(input logic m, input logic [1:0] s, input logic [3:0] a);
        logic [19:0] r;
        r = 20'hFFFFF;
        if (m) begin
            if (s == 2'b00) r = 20'h1FFFF;
        end else begin
            case (s)
                2'b01: if (a == 4'd0) r = 20'h2535F;
                2'b10: if (a == 4'd0) r = 20'h2A35F;
                2'b11: if (a == 4'd0) r = 20'h1089F;
                default: r = 20'hFFFFF;
            endcase
        end
        return r;
    endfunction

    always_comb card_in = rom(mask, card_slt, card_addr);

    // ---------------- check / driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [3:0] card, input logic [2:0] col, input logic [3:0] d);
        exp_q.push_back({card, col, d});
    endtask

    task automatic do_start(input logic m, input logic [1:0] s);
        sel_mask = m;
        sel_card = s;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int t0, input int exp_cyc, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        if (exp_cyc >= 0)
            check({tag, "_done_cycle"}, cyc - t0, exp_cyc);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && dig_if.digit_valid && dig_if.digit_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL xfer_unexpected observed=%0h expected=none",
                       {dig_if.digit_card, dig_if.digit_col, dig_if.digit});
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert ({dig_if.digit_card, dig_if.digit_col, dig_if.digit} === e) else begin
                    errors++;
                    $error("FAIL xfer_data observed=%0h expected=%0h",
                           {dig_if.digit_card, dig_if.digit_col, dig_if.digit}, e);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; sel_mask = 1'b0; sel_card = 2'b00;
        dig_if.digit_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_busy", busy, 1'b0);
        check("rst_valid", dig_if.digit_valid, 1'b0);
        check("rst_addr", card_addr, 4'd0);
        check("rst_slt", card_slt, 2'd0);
        check("rst_mask", mask, 1'b0);
        check("rst_count", card_count, 4'd0);
        check("rst_done", done, 1'b0);
        check("rst_sel_err", sel_err, 1'b0);

        // Equation deck 1: 2535F then blank
        push(0, 0, 4'h2); push(0, 1, 4'h5); push(0, 2, 4'h3); push(0, 3, 4'h5);
        t0 = cyc;
        do_start(1'b0, 2'b01);
        check("eq1_busy", busy, 1'b1);
        check("eq1_state_fetch", state_dbg, 3'd1);
        tick(); tick();
        check("eq1_first_valid", dig_if.digit_valid, 1'b1);
        check("eq1_first_digit", dig_if.digit, 4'h2);
        wait_done(50, t0, 10, "eq1");
        check("eq1_count", card_count, 4'd1);
        tick();
        check("eq1_done_pulse", done, 1'b0);
        check("eq1_idle", busy, 1'b0);
        check("eq1_q_empty", exp_q.size(), 0);

        // Mask deck X: fifteen 1FFFF cards, no wrap
        for (int i = 0; i < 15; i++) push(4'(i), 0, 4'h1);
        t0 = cyc;
        do_start(1'b1, 2'b00);
        wait_done(300, t0, 106, "mask");
        check("mask_count", card_count, 4'd15);
        check("mask_no_wrap", card_addr, 4'd14);
        check("mask_q_empty", exp_q.size(), 0);
        tick();

        // Backpressure on equation deck 3: 1089F
        push(0, 0, 4'h1); push(0, 1, 4'h0); push(0, 2, 4'h8); push(0, 3, 4'h9);
        dig_if.digit_ready = 1'b0;
        t0 = cyc;
        do_start(1'b0, 2'b11);
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            check("bp_hold_valid", dig_if.digit_valid, 1'b1);
            check("bp_hold_digit", dig_if.digit, 4'h1);
            check("bp_hold_col", dig_if.digit_col, 3'd0);
            tick();
        end
        dig_if.digit_ready = 1'b1;
        wait_done(50, t0, 14, "bp");
        check("bp_count", card_count, 4'd1);
        check("bp_q_empty", exp_q.size(), 0);
        tick();

        // Illegal select
        do_start(1'b0, 2'b00);
        check("ill_sel_err", sel_err, 1'b1);
        check("ill_busy", busy, 1'b0);
        tick();
        check("ill_sel_err_pulse", sel_err, 1'b0);
        check("ill_busy2", busy, 1'b0);
        check("ill_addr", card_addr, 4'd1);
        check("ill_slt", card_slt, 2'b11);
        check("ill_mask", mask, 1'b0);

        // Abort after two digits of 2535F
        push(0, 0, 4'h2); push(0, 1, 4'h5);
        do_start(1'b0, 2'b01);
        repeat (4) tick();
        abort = 1'b1;
        dig_if.digit_ready = 1'b0;
        tick();
        abort = 1'b0;
        dig_if.digit_ready = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", dig_if.digit_valid, 1'b0);
        check("abort_count", card_count, 4'd1);
        check("abort_q_empty", exp_q.size(), 0);
        for (int i = 0; i < 5; i++) begin
            check("abort_no_done", done, 1'b0);
            tick();
        end
        push(0, 0, 4'h2); push(0, 1, 4'h5); push(0, 2, 4'h3); push(0, 3, 4'h5);
        t0 = cyc;
        do_start(1'b0, 2'b01);
        check("restart_addr", card_addr, 4'd0);
        wait_done(50, t0, 10, "restart");
        tick();

        // abort + start together in IDLE: abort wins
        abort = 1'b1;
        do_start(1'b0, 2'b11);
        abort = 1'b0;
        check("abst_busy", busy, 1'b0);
        check("abst_slt", card_slt, 2'b01);
        tick();

        // Empty mask deck (mask=1, slt=01 all blank)
        t0 = cyc;
        do_start(1'b1, 2'b01);
        wait_done(20, t0, 3, "empty");
        check("empty_count", card_count, 4'd0);
        tick();

        // Deck with an A nibble: 2A35F
`ifdef CARD_BCD_CHECK_EN
        push(0, 0, 4'h2);
        do_start(1'b0, 2'b10);
        tick(); tick();
        check("bcd_first_digit", dig_if.digit, 4'h2);
        tick();
        check("bcd_sel_err", sel_err, 1'b1);
        check("bcd_no_valid", dig_if.digit_valid, 1'b0);
        tick();
        check("bcd_done", done, 1'b1);
        check("bcd_sel_err_pulse", sel_err, 1'b0);
        check("bcd_q_empty", exp_q.size(), 0);
`else
        push(0, 0, 4'h2); push(0, 1, 4'hA); push(0, 2, 4'h3); push(0, 3, 4'h5);
        t0 = cyc;
        do_start(1'b0, 2'b10);
        wait_done(50, t0, 10, "hex");
        check("hex_q_empty", exp_q.size(), 0);
`endif
        tick();

        // Reset mid-operation
        for (int i = 0; i < 15; i++) push(4'(i), 0, 4'h1);
        do_start(1'b1, 2'b00);
        repeat (8) tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        check("mrst_valid", dig_if.digit_valid, 1'b0);
        check("mrst_addr", card_addr, 4'd0);
        check("mrst_mask", mask, 1'b0);
        check("mrst_count", card_count, 4'd0);
        rst = 1'b0;
        tick();
        check("mrst_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/card_deck_sequencer.md
Name: card_deck_sequencer

Overview:
- Sequences reads of the punch-card ROM (15 cards × 20 bits, five 4-bit columns, nibble F = unpunched column).
- On a start command it selects one deck (equation card or power-of-10 mask deck), walks card addresses 0..14 and stops at the first blank card (20'hFFFFF) or after card 14.
- Streams every punched column out as a digit over a valid/ready handshake.
- Sits between the card ROM and the base-conversion/add-subtract datapath.

Parameters:
- N_CARDS, 15, cards per deck; last address = N_CARDS-1, must be ≤ 16.
- BLANK_CARD, 20'hFFFFF, terminator card value.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin deck read; honoured only in IDLE
- abort  input  1  cancel current deck read
- sel_mask  input  1  deck select: 1 = mask deck, 0 = equation deck
- sel_card  input  2  deck index, same encoding as ROM card_slt
- card_slt  output  2  to ROM
- mask  output  1  to ROM
- card_addr  output  4  to ROM
- card_in  input  20  ROM card_out, combinational from the three outputs above
- digit_valid  output  1  digit presented
- digit_ready  input  1  consumer accepts digit
- digit  output  4  column nibble, bits [19-4c:16-4c] for column c
- digit_col  output  3  column index 0..4, 0 = bits [19:16]
- digit_card  output  4  card address of the digit
- busy  output  1  state ≠ IDLE
- done  output  1  one-cycle pulse at deck end
- sel_err  output  1  one-cycle pulse on illegal select
- card_count  output  4  non-blank cards read in last/current deck

Behaviour:
- Reset values: all outputs 0; state IDLE; card_addr 0; card_slt 0; mask 0.
- Select latch: on accepted start, sel_mask/sel_card are latched into mask/card_slt and held until the next start.
- Illegal select: sel_mask=0 with sel_card=2'b00 (ROM floats). Response: sel_err pulses the next cycle, state stays IDLE, latches unchanged.
- States: IDLE, FETCH, SCAN, EMIT, DONE.
- IDLE → FETCH on legal start; card_addr←0; card_count←0.
- FETCH (1 cycle): card_reg←card_in; → SCAN.
- SCAN (1 cycle):
  - card_reg==BLANK_CARD → DONE.
  - Otherwise card_count++, col←0, → EMIT.
- EMIT, one column per cycle when not stalled:
  - Nibble F: no valid; column skipped in 1 cycle.
  - Otherwise digit_valid=1; digit, digit_col, digit_card held stable until digit_valid&&digit_ready; then col advances.
  - Leaving column 4: card_addr==N_CARDS-1 → DONE (no wrap); else card_addr++ → FETCH.
- DONE: done=1 for exactly one cycle; → IDLE.
- Outputs: digit_valid is combinational from state/col/card_reg (no dependence on digit_ready); digit_valid never drops without a transfer except on abort/rst.
- Latency: start accepted at edge k gives first possible valid in cycle k+3. Each card costs 2 + 5 cycles minimum with ready held high.
- abort:
  - In any non-IDLE state → IDLE next edge; digit_valid low from that cycle; no done pulse; card_count retains its value.
  - abort and start together in IDLE: abort wins, start ignored.
- start while busy: ignored.
- rst mid-operation: immediate return to reset values at the edge; no done.

Optional Feature:
- Macro: CARD_BCD_CHECK_EN.
- Defined: a nibble in A–E in EMIT is a corrupt punch. The sequencer does not present it, pulses sel_err for one cycle, then → DONE (done pulses the cycle after).
- Undefined: A–E nibbles are emitted as ordinary digits.

Test Plan:
- Equation deck 1 (sel_mask=0, sel_card=01, card0=2535F, card1=FFFFF), ready=1, start at cycle 0:
  - Digits 2,5,3,5 with cols 0..3 in cycles 3–6.
  - done in cycle 10; card_count=1.
- Mask X deck (sel_mask=1, sel_card=00, all cards 1FFFF), ready=1:
  - 15 transfers of digit 1, col 0, digit_card 0..14.
  - done after card 14 with no wrap; card_count=15.
- Backpressure on equation deck 3 (card0=1089F): ready=0 for 4 cycles on the first digit.
  - digit=1 / col 0 is held stable.
  - Then 1,0,8,9 are delivered in order, with no loss or duplication.
- sel_mask=0, sel_card=00, start → sel_err pulse one cycle, busy stays 0, card_addr unchanged.
- abort during EMIT after 2 digits of card 2535F → IDLE next cycle, digit_valid=0, no done, card_count=1. A new start restarts at card_addr 0.
- CARD_BCD_CHECK_EN defined, ROM card0 forced to 2A35F → digit 2 emitted, then sel_err, then done; A is never presented.
